// File: rtl/half_adder_core.sv
// half_adder_core: registered WIDTH-lane half adder with valid qualifier and summary flags
module half_adder_core #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Cout,
  output logic             carry_any,
  output logic             sum_parity
);
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("half_adder_core: WIDTH must be 1..64");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("half_adder_core: LATENCY must be 1 or 2");
  end
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] ca;
  logic [LATENCY-1:0] sp;
  logic [WIDTH-1:0]   s [LATENCY];
  logic [WIDTH-1:0]   c [LATENCY];
  logic [WIDTH-1:0]   s_in;
  logic [WIDTH-1:0]   c_in;
  // lane results and flags are formed before the first register so every stage carries a consistent set
  always_comb begin
    s_in = in1 ^ in2;
    c_in = in1 & in2;
  end
  // pipeline: valid bits always advance, data only moves when qualified so outputs stay still when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      v  <= '0;
      ca <= '0;
      sp <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        s[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      v[0] <= in_valid;
      if (in_valid) begin
        s[0]  <= s_in;
        c[0]  <= c_in;
        ca[0] <= |c_in;
        sp[0] <= ^s_in;
      end
      for (int k = 1; k < LATENCY; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          s[k]  <= s[k-1];
          c[k]  <= c[k-1];
          ca[k] <= ca[k-1];
          sp[k] <= sp[k-1];
        end
      end
    end
  end
  assign out_valid  = v[LATENCY-1];
  assign Sum        = s[LATENCY-1];
  assign Cout       = c[LATENCY-1];
  assign carry_any  = ca[LATENCY-1];
  assign sum_parity = sp[LATENCY-1];
endmodule

// File: tb/tb_half_adder_core.sv
// tb_half_adder_core: random and directed checks of two half_adder_core configurations against a history-based model
module tb_half_adder_core;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic [3:0] a = 0;
  logic [3:0] b = 0;
  logic       ov1, s1, c1, ca1, sp1;
  logic       ov4, ca4, sp4;
  logic [3:0] s4, c4;
  logic       hr [1024];
  logic       hv [1024];
  logic [3:0] ha [1024];
  logic [3:0] hb [1024];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  always #5 clk = ~clk;
  half_adder_core #(.WIDTH(1), .LATENCY(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in1(a[0]), .in2(b[0]),
    .out_valid(ov1), .Sum(s1), .Cout(c1), .carry_any(ca1), .sum_parity(sp1)
  );
  half_adder_core #(.WIDTH(4), .LATENCY(2)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in1(a), .in2(b),
    .out_valid(ov4), .Sum(s4), .Cout(c4), .carry_any(ca4), .sum_parity(sp4)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  // expected {valid, sum, cout} after edge e for a pipe of depth lat: the newest qualified input
  // that reached the output since the last reset, or zeros if none did
  function automatic logic [8:0] model(input int lat, input int e);
    int r = -1;
    logic [3:0] x = 0;
    logic [3:0] y = 0;
    logic vv;
    for (int j = 0; j <= e; j++) if (hr[j]) r = j;
    for (int j = r + 1; j <= e - lat + 1; j++) if (hv[j]) begin x = ha[j]; y = hb[j]; end
    vv = (e - lat + 1 > r) && (e - lat + 1 >= 0) && hv[e - lat + 1];
    return {vv, x ^ y, x & y};
  endfunction
  task automatic step(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
    logic [8:0] m1, m4;
    rst = r; in_valid = v; a = x; b = y;
    hr[cyc] = r; hv[cyc] = v; ha[cyc] = x; hb[cyc] = y;
    @(posedge clk);
    #1;
    m1 = model(1, cyc);
    m4 = model(2, cyc);
    check("w1_valid", 64'(ov1), 64'(m1[8]));
    check("w1_sum", 64'(s1), 64'(m1[4]));
    check("w1_cout", 64'(c1), 64'(m1[0]));
    check("w1_carry_any", 64'(ca1), 64'(m1[0]));
    check("w1_parity", 64'(sp1), 64'(m1[4]));
    check("w4_valid", 64'(ov4), 64'(m4[8]));
    check("w4_sum", 64'(s4), 64'(m4[7:4]));
    check("w4_cout", 64'(c4), 64'(m4[3:0]));
    check("w4_carry_any", 64'(ca4), 64'(|m4[3:0]));
    check("w4_parity", 64'(sp4), 64'(^m4[7:4]));
    cyc++;
  endtask
  initial begin
    step(1, 1, 4'hf, 4'hf);
    step(1, 1, 4'hf, 4'hf);
    step(0, 0, 4'hf, 4'hf);
    step(0, 0, 4'h0, 4'h0);
    step(0, 1, 4'h0, 4'h0);
    step(0, 1, 4'h1, 4'h0);
    step(0, 1, 4'h0, 4'h1);
    step(0, 1, 4'h1, 4'h1);
    step(0, 1, 4'hc, 4'ha);
    step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    step(0, 1, 4'hf, 4'hf);
    step(0, 0, 4'h0, 4'h0);
    step(0, 1, 4'h1, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    step(0, 1, 4'h3, 4'h5);
    step(0, 1, 4'h9, 4'hc);
    step(0, 1, 4'h7, 4'h7);
    step(0, 1, 4'he, 4'h1);
    step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    step(0, 1, 4'h6, 4'h3);
    step(0, 1, 4'h5, 4'ha);
    step(1, 1, 4'hf, 4'hf);
    step(0, 0, 4'h2, 4'h4);
    step(0, 0, 4'h8, 4'h8);
    step(0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/half_adder_core.md
Name: half_adder_core

Overview:
- Registered half adder with WIDTH independent 1-bit lanes.
- Each lane i computes Sum[i] = in1[i] XOR in2[i] and Cout[i] = in1[i] AND in2[i].
- A valid qualifier travels with the data, and two summary flags report across all lanes.
- Used as the leaf arithmetic primitive in adder/counter datapaths; with WIDTH=1 it is the classic single-bit half adder.

Parameters:
- WIDTH, 1, number of independent lanes. Legal range 1..64.
- LATENCY, 1, pipeline stages from inputs to outputs. Legal values 1 or 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in1/in2 in the current cycle.
- in1  input  WIDTH  operand A, one bit per lane.
- in2  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  Sum/Cout/flags hold a valid result.
- Sum  output  WIDTH  per-lane sum bit, in1 XOR in2.
- Cout  output  WIDTH  per-lane carry bit, in1 AND in2.
- carry_any  output  1  OR-reduction of the Cout being presented.
- sum_parity  output  1  XOR-reduction of the Sum being presented.

Behaviour:
- Reset: while rst=1 at a rising edge, all pipeline registers clear. Sum=0, Cout=0, out_valid=0, carry_any=0, sum_parity=0 from the next cycle on. rst has priority over in_valid.
- Reset mid-operation: any in-flight results are discarded, with no partial outputs. The first valid result after reset appears LATENCY cycles after the first accepted input.
- Truth table per lane, as in1,in2 -> Sum,Cout:
  - 0,0 -> 0,0
  - 1,0 -> 1,0
  - 0,1 -> 1,0
  - 1,1 -> 0,1
- Lanes are fully independent: there is no carry propagation between lanes.
- Latency is exactly LATENCY rising edges from an input sampled with in_valid=1 to the matching out_valid=1 with its result.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs in order.
- When in_valid=0 at an edge:
  - The stage valid bit clears.
  - The data registers of that stage hold their previous values, so outputs do not toggle while invalid.
  - Consumers must ignore data whenever out_valid=0.
- carry_any and sum_parity are registered together with Sum/Cout. They always describe the same result currently on Sum/Cout.
- There is no backpressure: the output must be consumed when out_valid=1.
- No X propagation: every output register is reset.
- Illegal WIDTH or LATENCY values must fail elaboration.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in1=1, in2=1 -> Sum=0, Cout=0, out_valid=0, carry_any=0, sum_parity=0 throughout, and for LATENCY cycles after release until the first accepted input emerges.
- Exhaustive truth table (WIDTH=1, LATENCY=1): apply (0,0), (1,0), (0,1), (1,1) on consecutive cycles with in_valid=1 -> one cycle later each, Sum/Cout = 0/0, 1/0, 1/0, 0/1 and out_valid=1 on four consecutive cycles.
- Lane independence (WIDTH=4): in1=4'b1100, in2=4'b1010 -> Sum=4'b0110, Cout=4'b1000, carry_any=1, sum_parity=0.
- Valid gaps: valid (1,1), then an idle cycle with in1=0, in2=0 and in_valid=0, then valid (1,0) -> out_valid pattern 1,0,1; Sum/Cout stay 0/1 through the idle cycle, then show 1/0.
- LATENCY=2 pipelining: stream four valid vectors back-to-back -> results appear in order starting exactly 2 cycles after the first input, with no bubbles.
- Reset mid-stream: assert rst for one cycle while results are in flight -> out_valid=0 the following cycle and no stale result appears afterwards.
